// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RISC-V decode stage. It has a valid/ready handshake
//               with a main register plus one skid entry, and a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_imm_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    if (ILEN != 32) begin : g_bad_ilen
        $error("decode_stage: ILEN must be 32");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end

    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_OP32     = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] c_FMT_R = 3'd0;
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      imm_fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    dec_t        dec_w;
    logic [31:0] imm32_w;
    logic [2:0]  fmt_w;
    logic        illegal_w;

    always_comb begin
        fmt_w     = c_FMT_R;
        illegal_w = 1'b0;
        unique case (in_instr[6:0])
            c_OPC_LOAD, c_OPC_OP_IMM, c_OPC_JALR,
            c_OPC_MISC_MEM, c_OPC_SYSTEM: fmt_w = c_FMT_I;
            c_OPC_STORE:                  fmt_w = c_FMT_S;
            c_OPC_BRANCH:                 fmt_w = c_FMT_B;
            c_OPC_LUI, c_OPC_AUIPC:       fmt_w = c_FMT_U;
            c_OPC_JAL:                    fmt_w = c_FMT_J;
            c_OPC_OP:                     fmt_w = c_FMT_R;
            c_OPC_OP_IMM32: begin
                if (XLEN == 64) fmt_w = c_FMT_I;
                else            illegal_w = 1'b1;
            end
            c_OPC_OP32: begin
                if (XLEN != 64) illegal_w = 1'b1;
            end
            default:                      illegal_w = 1'b1;
        endcase
    end

    // Immediates are assembled as 32-bit signed values and widened once, so U
    // sign-extends from bit 31 on RV64 like every other format.
    always_comb begin
        imm32_w = '0;
        case (fmt_w)
            c_FMT_I: imm32_w = {{20{in_instr[31]}}, in_instr[31:20]};
            c_FMT_S: imm32_w = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_FMT_B: imm32_w = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0};
            c_FMT_U: imm32_w = {in_instr[31:12], 12'b0};
            c_FMT_J: imm32_w = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0};
            default: imm32_w = '0;
        endcase
    end

    always_comb begin
        dec_w         = '0;
        dec_w.pc      = in_pc;
        dec_w.opcode  = in_instr[6:0];
        dec_w.rd      = in_instr[11:7];
        dec_w.rs1     = in_instr[19:15];
        dec_w.rs2     = in_instr[24:20];
        dec_w.funct3  = in_instr[14:12];
        dec_w.funct7  = in_instr[31:25];
        dec_w.illegal = illegal_w;
        dec_w.imm_fmt = illegal_w ? c_FMT_R : fmt_w;
        dec_w.imm     = illegal_w ? '0 : XLEN'($signed(imm32_w));
    end

    dec_t main_q, main_d, skid_q, skid_d;
    logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic accept_w, consume_w;

    assign in_ready  = ~skid_valid_q;
    assign accept_w  = in_valid & in_ready;
    assign consume_w = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume_w) begin
            // A full skid blocks accept, so refill from skid takes precedence.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_w) begin
                main_d       = dec_w;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_w) begin
            if (!main_valid_q) begin
                main_d       = dec_w;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec_w;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_imm_fmt = main_q.imm_fmt;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench; RV32 and RV64 instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_fmt;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_fmt;

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(32), .ILEN(32)) u_rv32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_opcode(a_opcode), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_funct3(a_funct3), .out_funct7(a_funct7), .out_imm_fmt(a_fmt),
        .out_imm(a_imm), .out_illegal(a_illegal)
    );

    decode_stage #(.XLEN(64), .ILEN(32)) u_rv64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_opcode(b_opcode), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_funct3(b_funct3), .out_funct7(b_funct7), .out_imm_fmt(b_fmt),
        .out_imm(b_imm), .out_illegal(b_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step(); step();
        checks++;
        if ({a_out_valid, a_in_ready, a_pc, a_imm, a_fmt, a_illegal} !== {1'b0, 1'b1, 32'd0, 32'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset32 got v=%b rdy=%b pc=%h imm=%h fmt=%0d ill=%b expected v=0 rdy=1 zeros",
                     a_out_valid, a_in_ready, a_pc, a_imm, a_fmt, a_illegal);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({b_out_valid, b_in_ready, b_pc, b_imm} !== {1'b0, 1'b1, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset64 got v=%b rdy=%b pc=%h imm=%h expected v=0 rdy=1 zeros",
                     b_out_valid, b_in_ready, b_pc, b_imm);
        end
    endtask

    task automatic test_single32();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 64'h100;
        step();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_rd, a_rs1, a_fmt, a_imm, a_illegal, a_pc, a_opcode} !==
            {1'b1, 5'd1, 5'd2, 3'd1, 32'hFFFFFFFF, 1'b0, 32'h100, 7'h13}) begin
            errors++;
            $display("FAIL addi32 got v=%b rd=%0d rs1=%0d fmt=%0d imm=%h ill=%b pc=%h op=%h expected 1 1 2 1 ffffffff 0 100 13",
                     a_out_valid, a_rd, a_rs1, a_fmt, a_imm, a_illegal, a_pc, a_opcode);
        end
        checks++;
        if (b_imm !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL addi64_imm got %h expected ffffffffffffffff", b_imm);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain got out_valid=%b expected 0", a_out_valid);
        end
        in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 64'h104;
        step();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_rd, a_rs1, a_rs2, a_funct3, a_funct7, a_fmt, a_imm, a_illegal} !==
            {1'b1, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0, 3'd3, 32'h00000008, 1'b0}) begin
            errors++;
            $display("FAIL beq got v=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%0d fmt=%0d imm=%h ill=%b expected 1 8 1 2 0 0 3 00000008 0",
                     a_out_valid, a_rd, a_rs1, a_rs2, a_funct3, a_funct7, a_fmt, a_imm, a_illegal);
        end
        step();
        in_valid = 1'b1; in_instr = 32'hFFDFF06F; in_pc = 64'h108;
        step();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_fmt, a_imm, a_rd} !== {1'b1, 3'd5, 32'hFFFFFFFC, 5'd0}) begin
            errors++;
            $display("FAIL jal got v=%b fmt=%0d imm=%h rd=%0d expected 1 5 fffffffc 0",
                     a_out_valid, a_fmt, a_imm, a_rd);
        end
        checks++;
        if (b_imm !== 64'hFFFFFFFFFFFFFFFC) begin
            errors++;
            $display("FAIL jal64_imm got %h expected fffffffffffffffc", b_imm);
        end
        step();
    endtask

    // Three back-to-back words at full throughput, each checked the cycle after accept.
    task automatic test_xlen64();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 64'h1_0000_0200;
        step();
        in_instr = 32'h800002B7; in_pc = 64'h1_0000_0204;
        checks++;
        if ({b_out_valid, b_rd, b_fmt, b_imm, b_illegal, b_pc} !==
            {1'b1, 5'd5, 3'd4, 64'h0000000012345000, 1'b0, 64'h1_0000_0200}) begin
            errors++;
            $display("FAIL lui64 got v=%b rd=%0d fmt=%0d imm=%h ill=%b pc=%h expected 1 5 4 0000000012345000 0 100000200",
                     b_out_valid, b_rd, b_fmt, b_imm, b_illegal, b_pc);
        end
        step();
        in_instr = 32'h0000003B; in_pc = 64'h1_0000_0208;
        checks++;
        if ({b_out_valid, b_imm} !== {1'b1, 64'hFFFFFFFF80000000}) begin
            errors++;
            $display("FAIL lui64_neg got v=%b imm=%h expected 1 ffffffff80000000", b_out_valid, b_imm);
        end
        checks++;
        if (a_imm !== 32'h80000000) begin
            errors++;
            $display("FAIL lui32_neg got imm=%h expected 80000000", a_imm);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({b_out_valid, b_fmt, b_illegal, b_imm} !== {1'b1, 3'd0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL op32_rv64 got v=%b fmt=%0d ill=%b imm=%h expected 1 0 0 0",
                     b_out_valid, b_fmt, b_illegal, b_imm);
        end
        checks++;
        if ({a_out_valid, a_fmt, a_illegal, a_imm} !== {1'b1, 3'd0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL op32_rv32 got v=%b fmt=%0d ill=%b imm=%h expected 1 0 1 0",
                     a_out_valid, a_fmt, a_illegal, a_imm);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h200;
        step();
        in_instr = 32'h00200093; in_pc = 64'h204;
        step();
        in_instr = 32'h00300093; in_pc = 64'h208;
        checks++;
        if ({a_in_ready, a_out_valid, a_pc} !== {1'b0, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL bp_full got rdy=%b v=%b pc=%h expected 0 1 200", a_in_ready, a_out_valid, a_pc);
        end
        step();
        checks++;
        if ({a_in_ready, a_pc} !== {1'b0, 32'h200}) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b pc=%h expected 0 200", a_in_ready, a_pc);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({a_in_ready, a_out_valid, a_pc, a_imm} !== {1'b1, 1'b1, 32'h204, 32'd2}) begin
            errors++;
            $display("FAIL bp_second got rdy=%b v=%b pc=%h imm=%h expected 1 1 204 2",
                     a_in_ready, a_out_valid, a_pc, a_imm);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_pc, a_imm} !== {1'b1, 32'h208, 32'd3}) begin
            errors++;
            $display("FAIL bp_third got v=%b pc=%h imm=%h expected 1 208 3", a_out_valid, a_pc, a_imm);
        end
        step();
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_empty got v=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 64'h300;
        step();
        in_instr = 32'h0000007F; in_pc = 64'h304;
        checks++;
        if ({a_out_valid, a_illegal, a_fmt, a_imm, a_pc} !== {1'b1, 1'b1, 3'd0, 32'd0, 32'h300}) begin
            errors++;
            $display("FAIL illegal_zero got v=%b ill=%b fmt=%0d imm=%h pc=%h expected 1 1 0 0 300",
                     a_out_valid, a_illegal, a_fmt, a_imm, a_pc);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({b_out_valid, b_illegal, b_fmt, b_imm, b_pc} !== {1'b1, 1'b1, 3'd0, 64'd0, 64'h304}) begin
            errors++;
            $display("FAIL illegal_7f got v=%b ill=%b fmt=%0d imm=%h pc=%h expected 1 1 0 0 304",
                     b_out_valid, b_illegal, b_fmt, b_imm, b_pc);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h400;
        step();
        in_pc = 64'h404;
        step();
        in_pc = 64'h408; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL flush got v32=%b rdy32=%b v64=%b rdy64=%b expected 0 1 0 1",
                     a_out_valid, a_in_ready, b_out_valid, b_in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got out_valid=%b pc=%h expected 0", a_out_valid, a_pc);
        end
        in_valid = 1'b1; in_pc = 64'h40C;
        step();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_pc} !== {1'b1, 32'h40C}) begin
            errors++;
            $display("FAIL flush_resume got v=%b pc=%h expected 1 40c", a_out_valid, a_pc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h500;
        step();
        in_pc = 64'h504;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_pc, b_out_valid, b_in_ready} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got v=%b rdy=%b pc=%h v64=%b rdy64=%b expected 0 1 0 0 1",
                     a_out_valid, a_in_ready, a_pc, b_out_valid, b_in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release got v=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single32();
        test_xlen64();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
